// File: rtl/red_pitaya_pll_drp_if.sv
// DRP port bundle between the reconfiguration sequencer (master) and the PLL (slave).
interface red_pitaya_pll_drp_if;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (output drp_daddr, drp_den, drp_dwe, drp_di, input drp_do, drp_drdy);
  modport slave  (input drp_daddr, drp_den, drp_dwe, drp_di, output drp_do, drp_drdy);
endinterface

// File: rtl/red_pitaya_pll_drp.sv
// ADC-clock PLL reconfiguration sequencer: holds the PLL in reset, read-modify-writes
// NREG DRP entries, releases reset and qualifies lock. Also runs the power-up lock sequence.
module red_pitaya_pll_drp #(
  parameter int unsigned NREG     = 4,
  parameter int unsigned DRDY_TO  = 64,
  parameter int unsigned LOCK_TO  = 65536,
  parameter int unsigned LOCK_STB = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_req,
  input  logic [7*NREG-1:0]    cfg_addr,
  input  logic [16*NREG-1:0]   cfg_mask,
  input  logic [16*NREG-1:0]   cfg_data,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [1:0]           err_code,
  output logic                 locked,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  red_pitaya_pll_drp_if.master drp
);

  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned DT_W  = $clog2(DRDY_TO + 1);
  localparam int unsigned LT_W  = $clog2(LOCK_TO + 1);
  localparam int unsigned ST_W  = $clog2(LOCK_STB + 1);
  localparam logic [1:0]  ERR_DRDY = 2'd1;
  localparam logic [1:0]  ERR_LOCK = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_ASSERT, S_RD, S_RD_W, S_WR, S_WR_W, S_RELEASE, S_LOCK_W, S_ERR
  } state_t;

  state_t           state;
  logic [1:0]       lock_meta;
  logic             lock_s;
  logic [6:0]       addr_q [NREG];
  logic [15:0]      mask_q [NREG];
  logic [15:0]      data_q [NREG];
  logic [IDX_W-1:0] idx;
  logic [DT_W-1:0]  drdy_tmr;
  logic [LT_W-1:0]  lock_tmr;
  logic [ST_W-1:0]  stb_cnt;
  logic [15:0]      do_cap;
  logic [1:0]       err_pend;
  logic [ST_W-1:0]  stb_next_c;

  // LOCKED is asynchronous to clk; only the synchronized copy is ever used.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lock_meta <= 2'b00;
    else       lock_meta <= {lock_meta[0], pll_locked};
  end
  assign lock_s = lock_meta[1];

  assign stb_next_c = lock_s ? stb_cnt + ST_W'(1) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_RELEASE;
      pll_rst       <= 1'b1;
      cfg_busy      <= 1'b1;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      err_code      <= 2'd0;
      locked        <= 1'b0;
      drp.drp_den   <= 1'b0;
      drp.drp_dwe   <= 1'b0;
      drp.drp_daddr <= 7'd0;
      drp.drp_di    <= 16'd0;
      idx           <= '0;
      drdy_tmr      <= '0;
      lock_tmr      <= '0;
      stb_cnt       <= '0;
      do_cap        <= 16'd0;
      err_pend      <= 2'd0;
      for (int i = 0; i < NREG; i++) begin
        addr_q[i] <= 7'd0;
        mask_q[i] <= 16'd0;
        data_q[i] <= 16'd0;
      end
    end else begin
      cfg_done    <= 1'b0;
      drp.drp_den <= 1'b0;
      drp.drp_dwe <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_req) begin
            for (int i = 0; i < NREG; i++) begin
              addr_q[i] <= cfg_addr[7*i +: 7];
              mask_q[i] <= cfg_mask[16*i +: 16];
              data_q[i] <= cfg_data[16*i +: 16];
            end
            cfg_err  <= 1'b0;
            err_code <= 2'd0;
            locked   <= 1'b0;
            idx      <= '0;
            cfg_busy <= 1'b1;
            pll_rst  <= 1'b1;
            state    <= S_ASSERT;
          end else if (locked && !lock_s) begin
            locked <= 1'b0;
          end
        end
        S_ASSERT: begin
          pll_rst <= 1'b1;
          state   <= S_RD;
        end
        S_RD: begin
          drp.drp_den   <= 1'b1;
          drp.drp_daddr <= addr_q[idx];
          drdy_tmr      <= '0;
          state         <= S_RD_W;
        end
        S_RD_W: begin
          if (drp.drp_drdy) begin
            do_cap <= drp.drp_do;
            state  <= S_WR;
          end else if (drdy_tmr == DT_W'(DRDY_TO)) begin
            err_pend <= ERR_DRDY;
            state    <= S_ERR;
          end else begin
            drdy_tmr <= drdy_tmr + DT_W'(1);
          end
        end
        S_WR: begin
          drp.drp_den   <= 1'b1;
          drp.drp_dwe   <= 1'b1;
          drp.drp_daddr <= addr_q[idx];
          drp.drp_di    <= (do_cap & mask_q[idx]) | (data_q[idx] & ~mask_q[idx]);
          drdy_tmr      <= '0;
          state         <= S_WR_W;
        end
        S_WR_W: begin
          if (drp.drp_drdy) begin
            if (idx == IDX_W'(NREG - 1)) begin
              state <= S_RELEASE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_RD;
            end
          end else if (drdy_tmr == DT_W'(DRDY_TO)) begin
            err_pend <= ERR_DRDY;
            state    <= S_ERR;
          end else begin
            drdy_tmr <= drdy_tmr + DT_W'(1);
          end
        end
        S_RELEASE: begin
          pll_rst  <= 1'b0;
          lock_tmr <= '0;
          stb_cnt  <= '0;
          state    <= S_LOCK_W;
        end
        // Any drop of the synced lock restarts the stability count from zero.
        S_LOCK_W: begin
          stb_cnt <= stb_next_c;
          if (stb_next_c == ST_W'(LOCK_STB)) begin
            locked   <= 1'b1;
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= S_IDLE;
          end else if (lock_tmr == LT_W'(LOCK_TO)) begin
            err_pend <= ERR_LOCK;
            state    <= S_ERR;
          end else begin
            lock_tmr <= lock_tmr + LT_W'(1);
          end
        end
        S_ERR: begin
          cfg_err  <= 1'b1;
          err_code <= err_pend;
          pll_rst  <= 1'b1;
          cfg_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_pll_drp.sv
// Scoreboard bench for red_pitaya_pll_drp with a behavioural DRP memory and PLL lock model.
module tb_red_pitaya_pll_drp;

  localparam int unsigned NREG = 4;
  localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;

  typedef struct {
    int          kind;
    logic [6:0]  addr;
    logic [15:0] di;
    logic [1:0]  code;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 cfg_req;
  logic [7*NREG-1:0]    cfg_addr;
  logic [16*NREG-1:0]   cfg_mask, cfg_data;
  logic                 cfg_busy, cfg_done, cfg_err, locked, pll_locked, pll_rst;
  logic [1:0]           err_code;

  red_pitaya_pll_drp_if drp_bus ();

  red_pitaya_pll_drp #(.NREG(NREG), .DRDY_TO(64), .LOCK_TO(65536), .LOCK_STB(256)) dut (
    .clk(clk), .rstn(rstn), .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
    .cfg_data(cfg_data), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .err_code(err_code), .locked(locked), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .drp(drp_bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  longint      cyc = 0;
  exp_t        exp_q[$];
  logic [15:0] env_mem [128];
  logic [15:0] ref_mem [128];
  logic [15:0] ref_save [128];
  logic [6:0]  cur_a [NREG];
  logic [15:0] cur_m [NREG];
  logic [15:0] cur_d [NREG];
  int          lock_d = 100, glitch_at = 0;
  bit          lock_never = 0, glitch_en = 0, force_low = 0, hang_en = 0;
  logic [6:0]  hang_addr = 7'd0;
  longint      t_fall = 0, t_done = 0, t_err = 0, t_den = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // DRP slave: random response latency, optionally never answers reads of hang_addr.
  initial begin
    int         pend;
    logic [6:0] pa;
    pend = 0; pa = 7'd0;
    drp_bus.drp_drdy = 1'b0;
    drp_bus.drp_do   = 16'd0;
    forever begin
      @(posedge clk); #1;
      drp_bus.drp_drdy = 1'b0;
      if (rstn !== 1'b1) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drp_bus.drp_drdy = 1'b1;
          drp_bus.drp_do   = env_mem[pa];
        end
      end else if (drp_bus.drp_den) begin
        pa = drp_bus.drp_daddr;
        if (drp_bus.drp_dwe) begin
          env_mem[pa] = drp_bus.drp_di;
          pend = $urandom_range(1, 4);
        end else if (hang_en && pa == hang_addr) pend = 0;
        else pend = $urandom_range(1, 4);
      end
    end
  end

  // PLL model: LOCKED rises lock_d cycles after RST falls, optional one-cycle glitch.
  initial begin
    int lcnt;
    lcnt = 0;
    pll_locked = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pll_rst !== 1'b0) begin
        lcnt = 0;
        pll_locked = 1'b0;
      end else begin
        lcnt++;
        pll_locked = !lock_never && !force_low && lcnt > lock_d && !(glitch_en && lcnt == glitch_at);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a DRP access or finishes.
  initial begin
    exp_t e;
    bit   err_prev, rst_prev;
    err_prev = 1'b0; rst_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        err_prev = 1'b0; rst_prev = 1'b1;
      end else begin
        if (rst_prev && !pll_rst) t_fall = cyc;
        rst_prev = pll_rst;
        if (drp_bus.drp_den) begin
          t_den = cyc;
          if (exp_q.size() == 0) chk("drp_unexpected_access", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("drp_kind", drp_bus.drp_dwe ? K_WR : K_RD, e.kind);
            chk("drp_addr", drp_bus.drp_daddr, e.addr);
            if (e.kind == K_WR) chk("drp_di", drp_bus.drp_di, e.di);
            chk("drp_pll_rst", pll_rst, 1);
          end
        end
        if (cfg_done) begin
          t_done = cyc;
          if (exp_q.size() == 0) chk("done_unexpected", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("done_kind", K_DONE, e.kind);
            chk("done_locked", locked, 1);
            chk("done_pll_rst", pll_rst, 0);
            chk("done_busy", cfg_busy, 0);
          end
        end
        if (cfg_err && !err_prev) begin
          t_err = cyc;
          if (exp_q.size() == 0) chk("err_unexpected", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("err_kind", K_ERR, e.kind);
            chk("err_code", err_code, e.code);
            chk("err_pll_rst", pll_rst, 1);
            chk("err_busy", cfg_busy, 0);
          end
        end
        err_prev = cfg_err;
      end
    end
  end

  task automatic push_exp(input int kind, input logic [6:0] a, input logic [15:0] di,
                          input logic [1:0] code);
    exp_t e;
    e.kind = kind; e.addr = a; e.di = di; e.code = code;
    exp_q.push_back(e);
  endtask

  // Reference: sequential read-modify-write of the DRP memory, then the expected outcome.
  task automatic model_push(input int hang_idx);
    logic [15:0] nv;
    for (int i = 0; i < NREG; i++) begin
      push_exp(K_RD, cur_a[i], 16'h0, 2'd0);
      if (i == hang_idx) begin
        push_exp(K_ERR, 7'h0, 16'h0, 2'd1);
        return;
      end
      nv = (ref_mem[cur_a[i]] & cur_m[i]) | (cur_d[i] & ~cur_m[i]);
      ref_mem[cur_a[i]] = nv;
      push_exp(K_WR, cur_a[i], nv, 2'd0);
    end
    if (lock_never) push_exp(K_ERR, 7'h0, 16'h0, 2'd2);
    else            push_exp(K_DONE, 7'h0, 16'h0, 2'd0);
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < NREG; i++) begin
      cur_a[i] = 7'($urandom);
      cur_m[i] = 16'($urandom);
      cur_d[i] = 16'($urandom);
    end
  endtask

  task automatic issue(input bit hold);
    for (int i = 0; i < NREG; i++) begin
      cfg_addr[7*i +: 7]   = cur_a[i];
      cfg_mask[16*i +: 16] = cur_m[i];
      cfg_data[16*i +: 16] = cur_d[i];
    end
    @(negedge clk); cfg_req = 1'b1;
    @(negedge clk); if (!hold) cfg_req = 1'b0;
    chk("req_busy", cfg_busy, 1);
    chk("req_err_cleared", cfg_err, 0);
    chk("req_code_cleared", err_code, 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (cfg_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({name, "_idle_timeout"}, cfg_busy, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_busy"}, cfg_busy, 1);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_done"}, cfg_done, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_code"}, err_code, 0);
    chk({tag, "_den"}, drp_bus.drp_den, 0);
    chk({tag, "_dwe"}, drp_bus.drp_dwe, 0);
    chk({tag, "_daddr"}, drp_bus.drp_daddr, 0);
    chk({tag, "_di"}, drp_bus.drp_di, 0);
  endtask

  task automatic run_cfg(input string name);
    model_push(-1);
    issue(1'b0);
    wait_idle(name, 3000);
    chk({name, "_latency"}, t_done - t_fall, lock_d + 258);
  endtask

  initial begin
    int n;
    cfg_req = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_data = '0;
    for (int i = 0; i < 128; i++) begin
      env_mem[i] = 16'($urandom);
      ref_mem[i] = env_mem[i];
    end
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1 check_reset("reset");

    // Power-up: lock 100 cycles after RST falls, done 2 sync + 256 stable cycles later.
    push_exp(K_DONE, 7'h0, 16'h0, 2'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_idle("powerup", 2000);
    chk("powerup_latency", t_done - t_fall, lock_d + 258);

    // Directed read-modify-write: all-ones contents, keep bit 12, set 0x0041.
    cur_a[0] = 7'h08; cur_a[1] = 7'h09; cur_a[2] = 7'h14; cur_a[3] = 7'h15;
    for (int i = 0; i < NREG; i++) begin
      env_mem[cur_a[i]] = 16'hFFFF;
      ref_mem[cur_a[i]] = 16'hFFFF;
      cur_m[i] = 16'h1000;
      cur_d[i] = 16'h0041;
    end
    run_cfg("directed");
    chk("directed_mem", env_mem[7'h15], 16'h1041);

    for (int r = 0; r < 5; r++) begin
      lock_d = $urandom_range(10, 150);
      rand_cfg();
      run_cfg("random");
    end

    // One-cycle lock glitch after ~200 stable cycles restarts qualification.
    lock_d = 100; glitch_en = 1'b1; glitch_at = lock_d + 201;
    rand_cfg();
    model_push(-1);
    issue(1'b0);
    wait_idle("glitch", 3000);
    chk("glitch_latency", t_done - t_fall, glitch_at + 258);
    glitch_en = 1'b0;

    // DRDY withheld on the entry-2 read.
    cur_a[0] = 7'h10; cur_a[1] = 7'h11; cur_a[2] = 7'h12; cur_a[3] = 7'h13;
    for (int i = 0; i < NREG; i++) begin
      cur_m[i] = 16'($urandom);
      cur_d[i] = 16'($urandom);
    end
    hang_en = 1'b1; hang_addr = 7'h12;
    model_push(2);
    issue(1'b0);
    wait_idle("drdy_to", 500);
    chk("drdy_to_cycles", t_err - t_den, 66);
    chk("drdy_to_pll_held", pll_rst, 1);
    hang_en = 1'b0;

    lock_d = 40;
    rand_cfg();
    run_cfg("after_drdy_err");

    // Lock never arrives.
    lock_never = 1'b1;
    rand_cfg();
    model_push(-1);
    issue(1'b0);
    wait_idle("lock_to", 70000);
    chk("lock_to_cycles", t_err - t_fall, 65538);
    chk("lock_to_locked", locked, 0);
    lock_never = 1'b0;

    lock_d = 50;
    rand_cfg();
    run_cfg("after_lock_err");

    // Lock drop while idle clears locked and does not restart a sequence.
    force_low = 1'b1;
    repeat (5) @(negedge clk);
    chk("drop_locked", locked, 0);
    chk("drop_busy", cfg_busy, 0);
    force_low = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_stays_unlocked", locked, 0);
    chk("drop_still_idle", cfg_busy, 0);

    // Request held high through the busy period yields exactly one sequence.
    rand_cfg();
    model_push(-1);
    issue(1'b1);
    repeat (30) @(negedge clk);
    cfg_req = 1'b0;
    wait_idle("held_req", 3000);
    chk("held_req_latency", t_done - t_fall, lock_d + 258);
    chk("held_req_queue", exp_q.size(), 0);

    // Reset pulsed while the first write is outstanding.
    rand_cfg();
    for (int i = 0; i < 128; i++) ref_save[i] = ref_mem[i];
    model_push(-1);
    issue(1'b0);
    n = 0;
    while (!(drp_bus.drp_den && drp_bus.drp_dwe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_saw_write", drp_bus.drp_den & drp_bus.drp_dwe, 1);
    #2 rstn = 1'b0;
    #1 check_reset("midrst");
    exp_q.delete();
    for (int i = 0; i < 128; i++) ref_mem[i] = ref_save[i];
    ref_mem[cur_a[0]] = (ref_save[cur_a[0]] & cur_m[0]) | (cur_d[0] & ~cur_m[0]);
    push_exp(K_DONE, 7'h0, 16'h0, 2'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_idle("midrst_powerup", 2000);
    chk("midrst_latency", t_done - t_fall, lock_d + 258);

    rand_cfg();
    run_cfg("final");
    for (int i = 0; i < 128; i++) chk("mem_image", env_mem[i], ref_mem[i]);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #980000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
